// File: rtl/mul_stream_acc.sv
// mul_stream_acc: counts the 1s of a unary product bitstream over a window of
// valid cycles and presents the binary count with a one-cycle valid pulse.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   i_start  - pulse that opens (or restarts) a window; its i_bit is not counted
//   i_len    - window length in valid cycles, 0 encodes 2^LOG_WIN
//   i_valid  - qualifies i_bit; low cycles are stalls
//   i_bit    - product bitstream bit
//   o_busy   - high while a window is open
//   o_valid  - one-cycle pulse when o_data has just been updated
//   o_data   - 1s count of the last completed window (held until the next one)
module mul_stream_acc #(
  parameter int unsigned LOG_WIN = 7,
  parameter int unsigned CNT_W   = LOG_WIN + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [LOG_WIN-1:0] i_len,
  input  logic               i_valid,
  input  logic               i_bit,
  output logic               o_busy,
  output logic               o_valid,
  output logic [CNT_W-1:0]   o_data
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [LOG_WIN:0] WinOne = {{LOG_WIN{1'b0}}, 1'b1};
  localparam logic [LOG_WIN:0] WinMax = {1'b1, {LOG_WIN{1'b0}}};

  state_e             state_q, state_d;
  logic [LOG_WIN:0]   win_cnt_q, win_cnt_d;
  logic [LOG_WIN:0]   len_q, len_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   data_q, data_d;

  logic [LOG_WIN:0]   len_dec;
  logic [LOG_WIN:0]   win_inc;
  logic [CNT_W-1:0]   acc_inc;

  assign len_dec = (i_len == '0) ? WinMax : {1'b0, i_len};
  assign win_inc = win_cnt_q + WinOne;
  assign acc_inc = acc_q + CNT_W'(i_bit);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    len_d     = len_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    case (state_q)
      // DONE only differs from IDLE in that a result is being held.
      StIdle, StDone: begin
        if (i_start) begin
          len_d     = len_dec;
          win_cnt_d = '0;
          acc_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (i_start) begin
          // Abort: restart the window, discard this cycle's bit, no result.
          len_d     = len_dec;
          win_cnt_d = '0;
          acc_d     = '0;
        end else if (i_valid) begin
          acc_d     = acc_inc;
          win_cnt_d = win_inc;
          if (win_inc == len_q) begin
            data_d  = acc_inc;
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // Busy decodes the state register only, so it stays free of input paths.
  assign o_busy  = (state_q == StRun);
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_mul_stream_acc.sv
// Scoreboard bench for mul_stream_acc: the driver keeps a transaction-level
// count of each window and queues {count, completion cycle}; an independent
// monitor pops and compares whenever o_valid is seen.
module tb_mul_stream_acc;

  localparam int LW = 7;
  localparam int CW = LW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic          i_valid = 1'b0;
  logic          i_bit = 1'b0;
  logic          o_busy;
  logic          o_valid;
  logic [CW-1:0] o_data;

  mul_stream_acc #(.LOG_WIN(LW), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_valid (i_valid),
    .i_bit   (i_bit),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  typedef struct {int cnt; int cyc;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rst_seen = 1'b0;
  bit mon_on   = 1'b0;
  int exp_hold = 0;

  // Reference window model: plain counting of the 1s in the first len valid bits.
  bit mdl_open = 1'b0;
  int mdl_len, mdl_cnt, mdl_ones;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input int len);
    i_start = 1'b1;
    i_len   = LW'(len);
    i_valid = 1'b1;
    i_bit   = 1'b1;  // must be ignored
    mdl_open = 1'b1;
    mdl_len  = (len == 0) ? (1 << LW) : len;
    mdl_cnt  = 0;
    mdl_ones = 0;
    tick();
    i_start = 1'b0;
    chk("busy_rise", int'(o_busy), 1);
  endtask

  task automatic feed(input bit b, input bit v);
    exp_t e;
    i_start = 1'b0;
    i_valid = v;
    i_bit   = b;
    if (mdl_open && v) begin
      mdl_cnt++;
      mdl_ones += int'(b);
      if (mdl_cnt == mdl_len) begin
        e.cnt = mdl_ones;
        e.cyc = cyc + 1;
        sb.push_back(e);
        mdl_open = 1'b0;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    i_valid  = 1'b1;
    i_bit    = 1'b1;
    mdl_open = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic bit [6:0] bitrev7(input bit [6:0] x);
    for (int k = 0; k < 7; k++) bitrev7[k] = x[6-k];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (rst_seen) begin
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_data", int'(o_data), 0);
        exp_hold = 0;
      end else if (o_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", int'(o_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("data", int'(o_data), e.cnt);
          chk("valid_cycle", cyc, e.cyc);
          chk("busy_in_valid", int'(o_busy), 0);
          exp_hold = e.cnt;
        end
      end else begin
        chk("data_hold", int'(o_data), exp_hold);
      end
    end
  end

  initial begin
    bit [9:0] pat;
    int n;
    pat = 10'b1101001101;  // LSB first: 1,0,1,1,0,0,1,0,1,1
    rst = 1'b1;
    tick();
    mon_on = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Full-length window of ones.
    start_win(0);
    for (int k = 0; k < 128; k++) feed(1'b1, 1'b1);

    // Length 10 with a three-cycle stall mid-window.
    start_win(10);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) for (int s = 0; s < 3; s++) feed(1'b1, 1'b0);
      feed(pat[k], 1'b1);
    end
    feed(1'b0, 1'b0);

    // Rate-coded product 64*32/128: bit-reversed comparator AND unary stream.
    start_win(0);
    for (int t = 0; t < 128; t++)
      feed((bitrev7(7'(t)) < 7'd64) && (t < 32), 1'b1);
    feed(1'b0, 1'b0);

    // Abort after 12 valid cycles, restart with length 5.
    start_win(20);
    for (int k = 0; k < 12; k++) feed(1'($urandom), 1'b1);
    start_win(5);
    for (int k = 0; k < 5; k++) feed(1'b1, 1'b1);
    feed(1'b0, 1'b0);

    // Reset at valid bit 50 of a full window, then a fresh window.
    start_win(0);
    for (int k = 0; k < 49; k++) feed(1'b1, 1'b1);
    do_reset();
    feed(1'b1, 1'b1);
    start_win(8);
    for (int k = 0; k < 8; k++) feed(1'(k % 3 == 0), 1'b1);

    // Back-to-back length-1 windows, restart in the o_valid cycle.
    feed(1'b0, 1'b0);
    start_win(1);
    feed(1'b1, 1'b1);
    start_win(1);
    feed(1'b0, 1'b1);
    feed(1'b1, 1'b0);
    feed(1'b1, 1'b0);

    // Random windows with stalls, gaps and occasional aborts.
    for (int w = 0; w < 8; w++) begin
      start_win(int'($urandom_range(0, 40)));
      n = 0;
      while (mdl_open && n < 1000) begin
        if ($urandom_range(0, 59) == 0) start_win(int'($urandom_range(1, 30)));
        else feed(1'($urandom), $urandom_range(0, 3) != 0);
        n++;
      end
      repeat ($urandom_range(0, 3)) feed(1'($urandom), 1'($urandom));
    end

    repeat (5) feed(1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
